wb_regfile: RTL and testbench

- Consumer end of the MEM/WB pipeline register: accepts writeback-stage signals and commits results into the 32x32 integer register file.
- Serves two combinational read ports to the decode stage, with write-first bypass of the same-cycle writeback.
- Maintains a retired-instruction counter and a registered one-cycle commit trace for the debug/trace interface.

---
 rtl/wb_regfile.sv | 50 +++++
 tb/tb_wb_regfile.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: WB-stage register file commit, two bypassed read ports, instret counter and registered commit trace
module wb_regfile #(
  parameter bit BYPASS_EN = 1'b1,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wb_rf_we,
  input  logic [4:0]           wb_wr,
  input  logic [31:0]          wb_rf_wdata,
  input  logic                 wb_have_inst,
  input  logic [31:0]          wb_pc,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  output logic [31:0]          id_rd1,
  output logic [31:0]          id_rd2,
  output logic [INSTRET_W-1:0] instret,
  output logic                 commit_valid,
  output logic [31:0]          commit_pc,
  output logic                 commit_we,
  output logic [4:0]           commit_wr,
  output logic [31:0]          commit_wdata
);
  logic [31:0] rf [32];
  logic        wen;
  always_comb begin
    wen    = wb_rf_we & wb_have_inst & (wb_wr != 5'd0);
    id_rd1 = (id_rs1 == 5'd0) ? 32'd0 : (BYPASS_EN && wen && wb_wr == id_rs1) ? wb_rf_wdata : rf[id_rs1];
    id_rd2 = (id_rs2 == 5'd0) ? 32'd0 : (BYPASS_EN && wen && wb_wr == id_rs2) ? wb_rf_wdata : rf[id_rs2];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      instret      <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= 32'd0;
      commit_we    <= 1'b0;
      commit_wr    <= 5'd0;
      commit_wdata <= 32'd0;
    end else begin
      if (wen) rf[wb_wr] <= wb_rf_wdata;
      instret      <= instret + INSTRET_W'(wb_have_inst);
      commit_valid <= wb_have_inst;
      commit_pc    <= wb_have_inst ? wb_pc : 32'd0;
      commit_we    <= wen;
      commit_wr    <= wen ? wb_wr : 5'd0;
      commit_wdata <= wen ? wb_rf_wdata : 32'd0;
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: randomized and directed checks of wb_regfile against a behavioural model
module tb_wb_regfile;
  logic clk_i = 1'b0, rst_i, wb_rf_we, wb_have_inst;
  logic [4:0] wb_wr, id_rs1, id_rs2;
  logic [31:0] wb_rf_wdata, wb_pc;
  logic [31:0] rd1_a, rd2_a, pc_a, wd_a, rd1_b, rd2_b, pc_b, wd_b, rd1_c, rd2_c, pc_c, wd_c;
  logic [63:0] ret_a, ret_b;
  logic [7:0] ret_c;
  logic cv_a, we_a, cv_b, we_b, cv_c, we_c;
  logic [4:0] wr_a, wr_b, wr_c;
  int n_chk = 0, n_err = 0;
  logic [31:0] m_rf [32];
  longint unsigned m_ret;
  logic m_cv, m_cwe;
  logic [31:0] m_cpc, m_cwd;
  logic [4:0] m_cwr;

  always #5 clk_i = ~clk_i;

  wb_regfile u_a (.clk_i(clk_i), .rst_i(rst_i), .wb_rf_we(wb_rf_we), .wb_wr(wb_wr), .wb_rf_wdata(wb_rf_wdata),
    .wb_have_inst(wb_have_inst), .wb_pc(wb_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd1(rd1_a), .id_rd2(rd2_a),
    .instret(ret_a), .commit_valid(cv_a), .commit_pc(pc_a), .commit_we(we_a), .commit_wr(wr_a), .commit_wdata(wd_a));
  wb_regfile #(.BYPASS_EN(1'b0)) u_b (.clk_i(clk_i), .rst_i(rst_i), .wb_rf_we(wb_rf_we), .wb_wr(wb_wr),
    .wb_rf_wdata(wb_rf_wdata), .wb_have_inst(wb_have_inst), .wb_pc(wb_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd1(rd1_b), .id_rd2(rd2_b), .instret(ret_b), .commit_valid(cv_b), .commit_pc(pc_b), .commit_we(we_b),
    .commit_wr(wr_b), .commit_wdata(wd_b));
  wb_regfile #(.INSTRET_W(8)) u_c (.clk_i(clk_i), .rst_i(rst_i), .wb_rf_we(wb_rf_we), .wb_wr(wb_wr),
    .wb_rf_wdata(wb_rf_wdata), .wb_have_inst(wb_have_inst), .wb_pc(wb_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd1(rd1_c), .id_rd2(rd2_c), .instret(ret_c), .commit_valid(cv_c), .commit_pc(pc_c), .commit_we(we_c),
    .commit_wr(wr_c), .commit_wdata(wd_c));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic m_wen();
    return wb_rf_we && wb_have_inst && wb_wr != 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] rs, input bit byp);
    if (rs == 0) return 32'd0;
    if (byp && m_wen() && wb_wr == rs) return wb_rf_wdata;
    return m_rf[rs];
  endfunction

  task automatic m_reset();
    foreach (m_rf[i]) m_rf[i] = 32'd0;
    m_ret = 0; m_cv = 0; m_cpc = 0; m_cwe = 0; m_cwr = 0; m_cwd = 0;
  endtask

  task automatic set_in(input logic r, we, hi, input logic [4:0] wr, input logic [31:0] wd, pc,
                        input logic [4:0] rs1, rs2);
    rst_i = r; wb_rf_we = we; wb_have_inst = hi; wb_wr = wr; wb_rf_wdata = wd; wb_pc = pc;
    id_rs1 = rs1; id_rs2 = rs2;
  endtask

  task automatic step();
    logic w;
    #1;
    chk("rd1_byp", rd1_a, m_read(id_rs1, 1));
    chk("rd2_byp", rd2_a, m_read(id_rs2, 1));
    chk("rd1_nobyp", rd1_b, m_read(id_rs1, 0));
    chk("rd2_nobyp", rd2_b, m_read(id_rs2, 0));
    w = m_wen();
    @(posedge clk_i);
    if (rst_i) m_reset();
    else begin
      if (w) m_rf[wb_wr] = wb_rf_wdata;
      m_ret += wb_have_inst ? 1 : 0;
      m_cv = wb_have_inst; m_cpc = wb_have_inst ? wb_pc : 0;
      m_cwe = w; m_cwr = w ? wb_wr : 0; m_cwd = w ? wb_rf_wdata : 0;
    end
    #1;
    chk("instret", ret_a, m_ret);
    chk("instret8", ret_c, m_ret % 256);
    chk("c_valid", cv_a, m_cv);
    chk("c_pc", pc_a, m_cpc);
    chk("c_we", we_a, m_cwe);
    chk("c_wr", wr_a, m_cwr);
    chk("c_wdata", wd_a, m_cwd);
  endtask

  initial begin
    set_in(1, 1, 1, 5'd3, 32'h77, 32'h0, 5'd0, 5'd0);
    @(posedge clk_i); #1;
    m_reset();
    set_in(0, 0, 0, 0, 0, 0, 5'd5, 5'd31);
    #1;
    chk("rst_rd1", rd1_a, 0);
    chk("rst_rd2", rd2_a, 0);
    chk("rst_instret", ret_a, 0);
    chk("rst_cvalid", cv_a, 0);
    step();
    set_in(0, 1, 1, 5'd7, 32'hDEADBEEF, 32'h100, 5'd7, 5'd7);
    #1;
    chk("byp_same", rd1_a, 32'hDEADBEEF);
    chk("nobyp_same", rd1_b, 32'h0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 5'd7, 5'd7);
    #1;
    chk("byp_next", rd2_a, 32'hDEADBEEF);
    chk("nobyp_next", rd2_b, 32'hDEADBEEF);
    chk("wr7_cwr", wr_a, 7);
    chk("wr7_instret", ret_a, 1);
    step();
    set_in(0, 1, 1, 5'd0, 32'h1234, 32'h104, 5'd0, 5'd0);
    step();
    chk("x0_cvalid", cv_a, 1);
    chk("x0_cwe", we_a, 0);
    set_in(0, 1, 0, 5'd3, 32'h55, 32'h108, 5'd3, 5'd0);
    step();
    chk("bubble_cvalid", cv_a, 0);
    chk("bubble_x3", rd1_a, 0);
    set_in(0, 1, 1, 5'd9, 32'hA5A5A5A5, 32'h10C, 5'd9, 5'd9);
    step();
    set_in(1, 1, 1, 5'd9, 32'h1, 32'h110, 5'd9, 5'd9);
    step();
    set_in(0, 0, 0, 0, 0, 0, 5'd9, 5'd9);
    #1;
    chk("rstwr_x9", rd1_a, 0);
    chk("rstwr_instret", ret_a, 0);
    step();
    set_in(0, 1, 1, 5'd4, 32'd1, 32'h200, 5'd4, 5'd5);
    #1; chk("b2b_rd1_0", rd1_a, 1); chk("b2b_rd2_0", rd2_a, 0);
    step();
    chk("b2b_cwr_0", wr_a, 4);
    set_in(0, 1, 1, 5'd4, 32'd2, 32'h204, 5'd4, 5'd5);
    #1; chk("b2b_rd1_1", rd1_a, 2); chk("b2b_rd2_1", rd2_a, 0);
    step();
    chk("b2b_cwr_1", wr_a, 4);
    set_in(0, 1, 1, 5'd5, 32'd3, 32'h208, 5'd4, 5'd5);
    #1; chk("b2b_rd1_2", rd1_a, 2); chk("b2b_rd2_2", rd2_a, 3);
    step();
    chk("b2b_cwr_2", wr_a, 5);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 256; i++) begin
      set_in(0, 0, 1, 5'(i), 32'(i), 32'(i * 4), 5'(i), 5'(i + 1));
      step();
    end
    chk("wrap_256", ret_c, 0);
    step();
    chk("wrap_257", ret_c, 1);
    for (int i = 0; i < 600; i++) begin
      logic [4:0] wr;
      wr = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(4));
      set_in($urandom_range(40) == 0, $urandom_range(3) != 0, $urandom_range(3) != 0, wr, $urandom, $urandom,
             ($urandom_range(1) == 0) ? wr : 5'($urandom), ($urandom_range(2) == 0) ? wr : 5'($urandom_range(4)));
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
